ahb_sram_responder: RTL and testbench



---
 rtl/ahb_sram_pkg.sv | 37 +++
 rtl/ahb_sram_array.sv | 24 ++
 rtl/ahb_sram_responder.sv | 110 +++++++++++
 tb/tb_ahb_sram_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// rtl/ahb_sram_pkg.sv - shared encodings, FSM states and byte-lane decode for the AHB SRAM responder
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } state_t;

  // Little-endian lane enables; illegal sizes never reach a write, so they map to none.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr;
      HSIZE_HALF: lanes = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes = 4'b1111;
      default:    lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - word-organised SRAM with byte-enable synchronous write and asynchronous read
module ahb_sram_array #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB-Lite slave terminating a matrix port onto an internal SRAM
// Address-phase capture, error decode, wait-state FSM and byte-lane write commit.
import ahb_sram_pkg::*;

module ahb_sram_responder #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic          r_write;
  logic [2:0]    r_size;

  state_t      w_next;
  logic [3:0]  w_cnt_next;
  logic        w_active;
  logic        w_take;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^HPROT;

  assign w_active = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  // Only states that drive HREADYOUT=1 can legally see an address phase complete.
  assign w_take   = w_active && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR2);

  assign w_err = (|HADDR[31:AW+2])
               || (HSIZE > HSIZE_WORD)
               || (HSIZE == HSIZE_HALF && HADDR[0])
               || (HSIZE == HSIZE_WORD && (|HADDR[1:0]));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_take) begin
        r_addr  <= HADDR[AW+1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_DONE;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      ST_ERR1: w_next = ST_ERR2;
      default: begin
        w_next = ST_IDLE;
        if (w_take) begin
          if (w_err) begin
            w_next = ST_ERR1;
          end else if (WS == 4'd0) begin
            w_next = ST_DONE;
          end else begin
            w_next     = ST_WAIT;
            w_cnt_next = WS - 4'd1;
          end
        end
      end
    endcase
  end

  assign HREADYOUT = !(r_state == ST_WAIT || r_state == ST_ERR1);
  assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  // Commit lands on the edge that closes DONE, so a pipelined read sees it next cycle.
  assign w_be   = (r_state == ST_DONE && r_write) ? byte_lanes(r_size, r_addr[1:0]) : 4'b0000;
  assign HRDATA = (r_state == ST_DONE && !r_write) ? w_rdata : 32'd0;

  ahb_sram_array #(.AW(AW)) u_array (
    .i_clk   (HCLK),
    .i_be    (w_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (HWDATA),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ahb_sram_responder.sv
// tb/tb_ahb_sram_responder.sv - directed bench for ahb_sram_responder at WAIT_STATES 0, 3 and 5
module tb_ahb_sram_responder;

  logic        clk;
  logic        rst   [3];
  logic        sel   [3];
  logic [31:0] addr  [3];
  logic [1:0]  trans [3];
  logic        wr    [3];
  logic [2:0]  size  [3];
  logic [31:0] wdata [3];
  logic        stall [3];
  wire         hro   [3];
  wire         hresp [3];
  wire  [31:0] hrd   [3];

  int n_pass = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      ahb_sram_responder #(
        .AW(10),
        .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
      ) u_dut (
        .HCLK      (clk),
        .HRESET    (rst[g]),
        .HSEL      (sel[g]),
        .HADDR     (addr[g]),
        .HTRANS    (trans[g]),
        .HWRITE    (wr[g]),
        .HSIZE     (size[g]),
        .HPROT     (4'b0011),
        .HREADY    (hro[g] & ~stall[g]),
        .HWDATA    (wdata[g]),
        .HREADYOUT (hro[g]),
        .HRESP     (hresp[g]),
        .HRDATA    (hrd[g])
      );
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input int d, input logic [1:0] t, input logic w,
                            input logic [2:0] sz, input logic [31:0] a);
    sel[d] = 1'b1; trans[d] = t; wr[d] = w; size[d] = sz; addr[d] = a;
  endtask

  task automatic go_idle(input int d);
    sel[d] = 1'b0; trans[d] = 2'b00;
  endtask

  // Single non-pipelined transfer; returns wait cycles seen, error flag and read data.
  task automatic xfer(input int d, input logic w, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int low, output logic err, output logic [31:0] rd);
    addr_phase(d, 2'b10, w, sz, a);
    tick();
    go_idle(d);
    wdata[d] = wd;
    low = 0;
    err = 1'b0;
    while (hro[d] !== 1'b1 && low < 40) begin
      if (hresp[d] === 1'b1) err = 1'b1;
      low++;
      tick();
    end
    if (hresp[d] === 1'b1) err = 1'b1;
    rd = hrd[d];
    tick();
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (hro[d] !== 1'b1 || hresp[d] !== 1'b0 || hrd[d] !== 32'd0)
        $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h want 1 0 00000000",
                 d, hro[d], hresp[d], hrd[d]);
      else n_pass++;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    addr_phase(0, 2'b10, 1'b1, 3'b010, 32'h10);
    tick();
    n_total++;
    if (hro[0] !== 1'b1) $display("FAIL b2b_wr_ready: got %b want 1", hro[0]);
    else n_pass++;
    wdata[0] = 32'hDEADBEEF;
    addr_phase(0, 2'b10, 1'b0, 3'b010, 32'h10);
    tick();
    go_idle(0);
    n_total++;
    if (hro[0] !== 1'b1 || hrd[0] !== 32'hDEADBEEF)
      $display("FAIL b2b_rd_data: got ready=%b rdata=%h want 1 deadbeef", hro[0], hrd[0]);
    else n_pass++;
    tick();
    n_total++;
    if (hro[0] !== 1'b1 || hrd[0] !== 32'd0)
      $display("FAIL b2b_idle: got ready=%b rdata=%h want 1 00000000", hro[0], hrd[0]);
    else n_pass++;
  endtask

  task automatic test_wait_bytes();
    int low;
    logic err;
    logic [31:0] rd;
    xfer(1, 1'b1, 3'b010, 32'h20, 32'h0, low, err, rd);
    n_total++;
    if (low != 3 || err !== 1'b0) $display("FAIL ws3_clear: got low=%0d err=%b want 3 0", low, err);
    else n_pass++;
    xfer(1, 1'b1, 3'b000, 32'h21, 32'h0000_1100, low, err, rd);
    n_total++;
    if (low != 3 || err !== 1'b0) $display("FAIL ws3_byte21: got low=%0d err=%b want 3 0", low, err);
    else n_pass++;
    xfer(1, 1'b1, 3'b000, 32'h23, 32'h2200_0000, low, err, rd);
    n_total++;
    if (low != 3 || err !== 1'b0) $display("FAIL ws3_byte23: got low=%0d err=%b want 3 0", low, err);
    else n_pass++;
    xfer(1, 1'b0, 3'b010, 32'h20, 32'h0, low, err, rd);
    n_total++;
    if (low != 3 || rd !== 32'h22001100)
      $display("FAIL ws3_read: got low=%0d rdata=%h want 3 22001100", low, rd);
    else n_pass++;
  endtask

  task automatic test_error();
    int low;
    logic err;
    logic [31:0] rd;
    xfer(0, 1'b1, 3'b010, 32'h0, 32'hCAFEF00D, low, err, rd);
    addr_phase(0, 2'b10, 1'b0, 3'b010, 32'h1000);
    tick();
    go_idle(0);
    n_total++;
    if (hro[0] !== 1'b0 || hresp[0] !== 1'b1 || hrd[0] !== 32'd0)
      $display("FAIL err1: got ready=%b resp=%b rdata=%h want 0 1 00000000", hro[0], hresp[0], hrd[0]);
    else n_pass++;
    tick();
    n_total++;
    if (hro[0] !== 1'b1 || hresp[0] !== 1'b1 || hrd[0] !== 32'd0)
      $display("FAIL err2: got ready=%b resp=%b rdata=%h want 1 1 00000000", hro[0], hresp[0], hrd[0]);
    else n_pass++;
    tick();
    n_total++;
    if (hro[0] !== 1'b1 || hresp[0] !== 1'b0)
      $display("FAIL err_after_idle: got ready=%b resp=%b want 1 0", hro[0], hresp[0]);
    else n_pass++;
    xfer(0, 1'b0, 3'b010, 32'h0, 32'h0, low, err, rd);
    n_total++;
    if (err !== 1'b0 || rd !== 32'hCAFEF00D)
      $display("FAIL err_next_ok: got err=%b rdata=%h want 0 cafef00d", err, rd);
    else n_pass++;
    xfer(0, 1'b1, 3'b010, 32'hFFC, 32'h0BADCAFE, low, err, rd);
    xfer(0, 1'b0, 3'b010, 32'hFFC, 32'h0, low, err, rd);
    n_total++;
    if (err !== 1'b0 || rd !== 32'h0BADCAFE)
      $display("FAIL top_word: got err=%b rdata=%h want 0 0badcafe", err, rd);
    else n_pass++;
    xfer(0, 1'b1, 3'b001, 32'h3, 32'hFFFFFFFF, low, err, rd);
    n_total++;
    if (err !== 1'b1 || low != 1) $display("FAIL half_misalign: got err=%b low=%0d want 1 1", err, low);
    else n_pass++;
    xfer(0, 1'b1, 3'b011, 32'h0, 32'hFFFFFFFF, low, err, rd);
    n_total++;
    if (err !== 1'b1 || low != 1) $display("FAIL size_dword: got err=%b low=%0d want 1 1", err, low);
    else n_pass++;
    xfer(0, 1'b0, 3'b010, 32'h0, 32'h0, low, err, rd);
    n_total++;
    if (rd !== 32'hCAFEF00D) $display("FAIL err_no_write: got %h want cafef00d", rd);
    else n_pass++;
    xfer(0, 1'b1, 3'b001, 32'h2, 32'hABCD0000, low, err, rd);
    xfer(0, 1'b0, 3'b010, 32'h0, 32'h0, low, err, rd);
    n_total++;
    if (err !== 1'b0 || rd !== 32'hABCDF00D)
      $display("FAIL half_upper: got err=%b rdata=%h want 0 abcdf00d", err, rd);
    else n_pass++;
  endtask

  task automatic test_no_accept();
    addr_phase(0, 2'b01, 1'b0, 3'b010, 32'h0);
    tick();
    n_total++;
    if (hro[0] !== 1'b1 || hresp[0] !== 1'b0 || hrd[0] !== 32'd0)
      $display("FAIL busy_ignored: got ready=%b resp=%b rdata=%h want 1 0 00000000", hro[0], hresp[0], hrd[0]);
    else n_pass++;
    trans[0] = 2'b10;
    stall[0] = 1'b1;
    tick();
    n_total++;
    if (hro[0] !== 1'b1 || hresp[0] !== 1'b0 || hrd[0] !== 32'd0)
      $display("FAIL stall_ignored: got ready=%b resp=%b rdata=%h want 1 0 00000000", hro[0], hresp[0], hrd[0]);
    else n_pass++;
    stall[0] = 1'b0;
    tick();
    n_total++;
    if (hrd[0] !== 32'hABCDF00D) $display("FAIL stall_release: got %h want abcdf00d", hrd[0]);
    else n_pass++;
    sel[0] = 1'b0;
    tick();
    n_total++;
    if (hrd[0] !== 32'd0) $display("FAIL unselected: got %h want 00000000", hrd[0]);
    else n_pass++;
    go_idle(0);
    tick();
  endtask

  task automatic test_reset_mid();
    int low;
    logic err;
    logic [31:0] rd;
    xfer(2, 1'b1, 3'b010, 32'h40, 32'h55AA55AA, low, err, rd);
    n_total++;
    if (low != 5) $display("FAIL ws5_low: got %0d want 5", low);
    else n_pass++;
    addr_phase(2, 2'b10, 1'b1, 3'b010, 32'h40);
    tick();
    go_idle(2);
    wdata[2] = 32'hFFFFFFFF;
    tick();
    n_total++;
    if (hro[2] !== 1'b0) $display("FAIL ws5_in_wait: got %b want 0", hro[2]);
    else n_pass++;
    rst[2] = 1'b1;
    #1;
    n_total++;
    if (hro[2] !== 1'b1 || hresp[2] !== 1'b0 || hrd[2] !== 32'd0)
      $display("FAIL async_reset: got ready=%b resp=%b rdata=%h want 1 0 00000000", hro[2], hresp[2], hrd[2]);
    else n_pass++;
    tick();
    tick();
    rst[2] = 1'b0;
    tick();
    xfer(2, 1'b0, 3'b010, 32'h40, 32'h0, low, err, rd);
    n_total++;
    if (rd !== 32'h55AA55AA || low != 5)
      $display("FAIL reset_dropped_write: got rdata=%h low=%0d want 55aa55aa 5", rd, low);
    else n_pass++;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; addr[d] = 32'd0; trans[d] = 2'b00;
      wr[d] = 1'b0; size[d] = 3'b010; wdata[d] = 32'd0; stall[d] = 1'b0;
    end
    test_reset();
    test_back_to_back();
    test_wait_bytes();
    test_error();
    test_no_accept();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
